iadder_pipe: RTL and testbench

//  Pipelined, parametrised immediate/target-address generator for the RV32I core.

---
 rtl/iadder_pkg.sv | 30 +++
 rtl/iadder_skid_buf.sv | 84 ++++++++
 rtl/iadder_pipe.sv | 114 +++++++++++
 tb/tb_iadder_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iadder_pkg.sv
// ---------------------------------------------------------------------------
// iadder_pkg
//   Shared types and constants for the RV32I target-address generator.
//   - iadder_mode_e   : operand-selection mode carried on mode_in
//   - iadder_result_t : result record at the default widths, for consumers
//                       that want a typed view of the generator output
//   - LINK_INC        : link-address increment (pc + 4)
// ---------------------------------------------------------------------------
package iadder_pkg;

    localparam int IADDER_XLEN  = 32;
    localparam int IADDER_TAG_W = 4;
    localparam int LINK_INC     = 4;

    typedef enum logic [1:0] {
        IADDER_PC_REL  = 2'b00,
        IADDER_RS1_REL = 2'b01,
        IADDER_JALR    = 2'b10,
        IADDER_RSVD    = 2'b11
    } iadder_mode_e;

    typedef struct packed {
        logic [IADDER_XLEN-1:0]  target;
        logic [IADDER_XLEN-1:0]  link;
        logic                    illegal;
        logic                    misalign;
        logic [IADDER_TAG_W-1:0] tag;
    } iadder_result_t;

endpackage

// File: rtl/iadder_skid_buf.sv
// ---------------------------------------------------------------------------
// iadder_skid_buf
//   Generic 2-entry skid buffer: an output register (OR) feeding the consumer
//   and a skid register (SR) that catches one op while the OR is stalled.
//   in_ready_out comes straight from a flop, so there is no combinational
//   path from out_ready_in back to the producer. Strict FIFO order.
// Ports
//   clk_in        in   clock, rising edge
//   rst_in        in   synchronous active-high reset
//   flush_in      in   drop every buffered op; the op offered this cycle too
//   in_valid_in   in   producer has an op
//   in_ready_out  out  buffer accepts an op this cycle (SR empty)
//   in_data_in    in   W-bit payload
//   out_valid_out out  OR holds a result
//   out_ready_in  in   consumer takes the OR this cycle
//   out_data_out  out  OR payload, held while stalled
// ---------------------------------------------------------------------------
module iadder_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush_in,
    input  logic         in_valid_in,
    output logic         in_ready_out,
    input  logic [W-1:0] in_data_in,
    output logic         out_valid_out,
    input  logic         out_ready_in,
    output logic [W-1:0] out_data_out
);

    logic         or_valid;
    logic         sr_valid;
    logic [W-1:0] or_data;
    logic [W-1:0] sr_data;
    logic         accept;
    logic         or_load;

    // Flush beats accept: an op offered during a flush is discarded.
    // OR may take new data whenever it is empty or being drained.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise the tool infers a latch.
    always_comb begin
        accept  = in_valid_in & ~sr_valid & ~flush_in;
        or_load = ~or_valid | out_ready_in;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the payload registers are reset as well, because the
            // outputs must read zero straight after reset, not just be invalid.
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
            or_data  <= '0;
            sr_data  <= '0;
        end else if (flush_in) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
        end else if (or_load) begin
            if (sr_valid) begin
                // Older op in SR goes first; accept is 0 here since ready was 0.
                or_data  <= sr_data;
                or_valid <= 1'b1;
                sr_valid <= 1'b0;
            end else begin
                or_valid <= accept;
                if (accept) begin
                    or_data <= in_data_in;
                end
            end
        end else if (accept) begin
            // OR stalled: park the new op in SR, which drops ready next cycle.
            sr_valid <= 1'b1;
            sr_data  <= in_data_in;
        end
    end

    assign in_ready_out  = ~sr_valid;
    assign out_valid_out = or_valid;
    assign out_data_out  = or_data;

endmodule

// File: rtl/iadder_pipe.sv
// ---------------------------------------------------------------------------
// iadder_pipe
//   Pipelined target-address generator for the RV32I core. A combinational
//   compute stage forms the target (pc- or rs1-relative, JALR bit-0 clear),
//   the link address pc+4 and the reserved-mode flag; iadder_skid_buf gives
//   one cycle of latency with full throughput under valid/ready handshakes.
//   Optional feature macro: IADDER_MISALIGN_CHECK_EN -- when defined,
//   misalign_out flags a target not aligned to ALIGN_BYTES (after the JALR
//   mask); when undefined misalign_out is constant 0.
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   flush_in            drop all buffered ops (and the one offered now)
//   in_valid_in/in_ready_out    input handshake
//   mode_in             iadder_mode_e encoding
//   pc_in, rs1_in, imm_in       XLEN operands (imm already sign-extended)
//   tag_in / tag_out    opaque sideband tag, passed through
//   out_valid_out/out_ready_in  output handshake
//   target_out, link_out        computed addresses
//   illegal_out         mode was reserved
//   misalign_out        target misaligned (feature macro above)
// ---------------------------------------------------------------------------
module iadder_pipe
    import iadder_pkg::*;
#(
    parameter int XLEN        = IADDER_XLEN,
    parameter int TAG_W       = IADDER_TAG_W,
    parameter int ALIGN_BYTES = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [1:0]       mode_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [XLEN-1:0]  target_out,
    output logic [XLEN-1:0]  link_out,
    output logic             illegal_out,
    output logic             misalign_out,
    output logic [TAG_W-1:0] tag_out
);

    // Same field layout as iadder_pkg::iadder_result_t, re-declared here so
    // that non-default XLEN/TAG_W stay consistent.
    typedef struct packed {
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic             illegal;
        logic             misalign;
        logic [TAG_W-1:0] tag;
    } result_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);

`ifdef IADDER_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    // Constant 0 folds the alignment compare away entirely.
    localparam bit MISALIGN_EN = 1'b0;
`endif

    iadder_mode_e    mode;
    logic [XLEN-1:0] sum_pc;
    logic [XLEN-1:0] sum_rs1;
    result_t         res;
    result_t         out_res;

    always_comb begin
        mode        = iadder_mode_e'(mode_in);
        // XLEN-wide sums wrap modulo 2^XLEN; the carry is intentionally lost.
        sum_pc      = pc_in + imm_in;
        sum_rs1     = rs1_in + imm_in;
        res         = '0;
        res.link    = pc_in + XLEN'(LINK_INC);
        res.tag     = tag_in;
        case (mode)
            IADDER_PC_REL:  res.target = sum_pc;
            IADDER_RS1_REL: res.target = sum_rs1;
            IADDER_JALR:    res.target = {sum_rs1[XLEN-1:1], 1'b0};
            default: begin
                res.target  = sum_pc;
                res.illegal = 1'b1;
            end
        endcase
        // Checked after the JALR mask, so JALR bit 0 never flags.
        res.misalign = MISALIGN_EN & (|(res.target & ALIGN_MASK));
    end

    iadder_skid_buf #(
        .W ($bits(result_t))
    ) u_skid (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (flush_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .in_data_in    (res),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .out_data_out  (out_res)
    );

    assign target_out   = out_res.target;
    assign link_out     = out_res.link;
    assign illegal_out  = out_res.illegal;
    assign misalign_out = out_res.misalign;
    assign tag_out      = out_res.tag;

endmodule

// File: tb/tb_iadder_pipe.sv
// ---------------------------------------------------------------------------
// tb_iadder_pipe
//   Self-checking bench for iadder_pipe: directed cases with literal
//   expectations, then randomized traffic with random backpressure, flushes
//   and resets, all compared every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_iadder_pipe;

`ifdef IADDER_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [3:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] target;
    logic [31:0] link;
    logic        illegal;
    logic        misalign;
    logic [3:0]  tag_o;

    always #5 clk = ~clk;

    iadder_pipe #(
        .XLEN        (32),
        .TAG_W       (4),
        .ALIGN_BYTES (4)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .flush_in      (flush),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .mode_in       (mode),
        .pc_in         (pc),
        .rs1_in        (rs1),
        .imm_in        (imm),
        .tag_in        (tag),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .target_out    (target),
        .link_out      (link),
        .illegal_out   (illegal),
        .misalign_out  (misalign),
        .tag_out       (tag_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    typedef struct packed {
        logic [31:0] target;
        logic [31:0] link;
        logic        illegal;
        logic        misalign;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic reduced modulo 2^32.
    function automatic exp_t model(input logic [1:0] m, input logic [31:0] p,
                                   input logic [31:0] r, input logic [31:0] i,
                                   input logic [3:0] tg);
        exp_t           e;
        longint unsigned base;
        longint unsigned t;
        base = (m == 2'd1 || m == 2'd2) ? 64'(r) : 64'(p);
        t    = (base + 64'(i)) % 64'h1_0000_0000;
        if (m == 2'd2) t = t - (t % 2);
        e.target   = t[31:0];
        e.link     = 32'((64'(p) + 64'd4) % 64'h1_0000_0000);
        e.illegal  = (m == 2'd3);
        e.misalign = MIS_EN && ((t % 4) != 0);
        e.tag      = tg;
        return e;
    endfunction

    // Occupancy model: up to two results in flight, one-cycle latency,
    // ready whenever fewer than two are held.
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            bit acc;
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(model(mode, pc, rs1, imm, tag));
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0 && out_valid) begin
                check("target", 64'(target), 64'(q[0].target));
                check("link", 64'(link), 64'(q[0].link));
                check("illegal", 64'(illegal), 64'(q[0].illegal));
                check("misalign", 64'(misalign), 64'(q[0].misalign));
                check("tag", 64'(tag_o), 64'(q[0].tag));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] p, input logic [31:0] r,
                        input logic [31:0] i, input logic [3:0] tg);
        in_valid = 1'b1;
        mode = m; pc = p; rs1 = r; imm = i; tag = tg;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
        check({pfx, "_target"}, 64'(target), 64'd0);
        check({pfx, "_link"}, 64'(link), 64'd0);
        check({pfx, "_tag"}, 64'(tag_o), 64'd0);
        check({pfx, "_illegal"}, 64'(illegal), 64'd0);
        check({pfx, "_misalign"}, 64'(misalign), 64'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'd0; pc = '0; rs1 = '0; imm = '0; tag = '0;
        @(posedge clk);
        armed = 1'b1;
        #1;
        step();
        rst = 1'b0;
        check_zero_outputs("reset");

        // Pin the model itself with hand-computed values.
        e = model(2'd2, 32'h0, 32'h1002, 32'h1, 4'h0);
        check("model_jalr", 64'(e.target), 64'h1002);
        e = model(2'd0, 32'hFFFF_FFFC, 32'h0, 32'h8, 4'h0);
        check("model_wrap_link", 64'(e.link), 64'h0);

        // PC_REL basic.
        send(2'd0, 32'h100, 32'h0, 32'h20, 4'h1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_target", 64'(target), 64'h120);
        check("t1_link", 64'(link), 64'h104);
        check("t1_tag", 64'(tag_o), 64'h1);

        // JALR masking and optional misalignment.
        send(2'd2, 32'h0, 32'h1001, 32'h4, 4'h2);
        check("t2a_target", 64'(target), 64'h1004);
        check("t2a_misalign", 64'(misalign), 64'd0);
        send(2'd2, 32'h0, 32'h1002, 32'h1, 4'h3);
        check("t2b_target", 64'(target), 64'h1002);
        check("t2b_misalign", 64'(misalign), 64'(MIS_EN));

        // Wrap-around of both sums.
        send(2'd0, 32'hFFFF_FFFC, 32'h0, 32'h8, 4'h4);
        check("t3_target", 64'(target), 64'h4);
        check("t3_link", 64'(link), 64'h0);

        // Reserved mode.
        send(2'd3, 32'h200, 32'hDEAD_0000, 32'h10, 4'h5);
        check("t5_target", 64'(target), 64'h210);
        check("t5_illegal", 64'(illegal), 64'd1);

        // RS1_REL with negative immediate.
        send(2'd1, 32'h500, 32'h3000, 32'hFFFF_FFF0, 4'h6);
        check("rs1_target", 64'(target), 64'h2FF0);
        check("rs1_link", 64'(link), 64'h504);
        check("rs1_illegal", 64'(illegal), 64'd0);
        step();

        // Backpressure: two held, third blocked, then FIFO release.
        out_ready = 1'b0;
        send(2'd0, 32'h10, 32'h0, 32'h0, 4'h7);
        send(2'd0, 32'h20, 32'h0, 32'h0, 4'h8);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        check("bp_head", 64'(tag_o), 64'h7);
        in_valid = 1'b1; mode = 2'd0; pc = 32'h30; tag = 4'h9;
        step();
        check("bp_hold_tag", 64'(tag_o), 64'h7);
        check("bp_hold_target", 64'(target), 64'h10);
        out_ready = 1'b1;
        step();
        check("bp_second", 64'(tag_o), 64'h8);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_third", 64'(tag_o), 64'h9);
        for (int k = 10; k < 16; k++) begin
            send(2'd1, 32'h0, 32'(k * 16), 32'h4, 4'(k));
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_tag", 64'(tag_o), 64'(k));
        end
        step();

        // Flush with both registers full; the op offered during flush is lost.
        out_ready = 1'b0;
        send(2'd0, 32'h40, 32'h0, 32'h0, 4'h1);
        send(2'd0, 32'h50, 32'h0, 32'h0, 4'h2);
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1; in_valid = 1'b1; tag = 4'h3;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        step();
        check("fl_dropped", 64'(out_valid), 64'd0);

        // Reset mid-stream.
        send(2'd0, 32'h1234, 32'h0, 32'h4, 4'hA);
        send(2'd0, 32'h5678, 32'h0, 32'h4, 4'hB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero_outputs("midrst");
        out_ready = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 255) == 0);
            mode      = 2'($urandom_range(0, 3));
            pc        = $urandom;
            rs1       = $urandom;
            imm       = $urandom;
            tag       = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) pc  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rs1 = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step();
        end

        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        check("drain_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
